// File: rtl/iir_filter_mc.sv
// Multi-channel direct-form-I IIR filter; one sequential MAC is shared by all channels.
// Optional build macro IIR_SAT_COUNT_EN adds the o_sat_cnt saturation counter port.
module iir_filter_mc #(
    parameter  int DATA_W    = 24,
    parameter  int COEF_W    = 18,
    parameter  int COEF_FRAC = 16,
    parameter  int ORDER     = 4,
    parameter  int NUM_CH    = 2,
    parameter  int ACC_GUARD = 4,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     i_CLK,
    input  logic                     i_RST,
    input  logic signed [DATA_W-1:0] i_NewSample,
    input  logic                     i_NewSample_valid,
    input  logic [CH_W-1:0]          i_NewSample_ch,
    output logic                     o_sample_ready,
    input  logic                     i_coef_we,
    input  logic [3:0]               i_coef_addr,
    input  logic signed [COEF_W-1:0] i_coef_data,
    output logic                     o_busy,
    output logic signed [DATA_W-1:0] o_result,
    output logic [CH_W-1:0]          o_result_ch,
    output logic                     o_result_valid,
    input  logic                     i_result_ack,
    output logic                     o_ch_err
`ifdef IIR_SAT_COUNT_EN
    ,
    output logic [15:0]              o_sat_cnt
`endif
);

    localparam int NUM_TAPS = 2 * ORDER + 1;
    localparam int PROD_W   = DATA_W + COEF_W;
    localparam int ACC_W    = PROD_W + ACC_GUARD;
    localparam int STEP_W   = $clog2(NUM_TAPS);
    localparam int HIST_W   = (ORDER > 1) ? $clog2(ORDER) : 1;

    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_TAPS - 1);
    localparam logic [STEP_W-1:0] A_BASE    = STEP_W'(ORDER + 1);

    localparam logic signed [COEF_W-1:0] COEF_ONE =
        {{(COEF_W - COEF_FRAC - 1){1'b0}}, 1'b1, {COEF_FRAC{1'b0}}};
    localparam logic signed [ACC_W-1:0] ROUND_BIAS =
        {{(ACC_W - COEF_FRAC){1'b0}}, 1'b1, {(COEF_FRAC - 1){1'b0}}};
    localparam logic signed [DATA_W-1:0] DATA_MAX = {1'b0, {(DATA_W - 1){1'b1}}};
    localparam logic signed [DATA_W-1:0] DATA_MIN = {1'b1, {(DATA_W - 1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_MAC,
        S_SCALE,
        S_OUT
    } state_t;

    state_t state_q, state_d;

    logic signed [COEF_W-1:0] coef_q [NUM_TAPS];
    logic signed [DATA_W-1:0] x_hist [NUM_CH][ORDER];
    logic signed [DATA_W-1:0] y_hist [NUM_CH][ORDER];

    logic signed [DATA_W-1:0] x_new_q;
    logic [CH_W-1:0]          ch_q;
    logic [STEP_W-1:0]        step_q;
    logic signed [ACC_W-1:0]  acc_q;

    logic                     ch_legal;
    logic [HIST_W-1:0]        hist_idx;
    logic signed [DATA_W-1:0] operand;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  shifted;
    logic                     sat_hi;
    logic                     sat_lo;
    logic                     is_sat;
    logic signed [DATA_W-1:0] result_sat;

    assign ch_legal = int'(i_NewSample_ch) < NUM_CH;

    // State register.
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        o_sample_ready = 1'b0;
        o_busy         = 1'b1;
        unique case (state_q)
            S_IDLE: begin
                o_sample_ready = 1'b1;
                o_busy         = 1'b0;
                if (i_NewSample_valid && ch_legal) begin
                    state_d = S_MAC;
                end
            end
            S_MAC: begin
                if (step_q == LAST_STEP) begin
                    state_d = S_SCALE;
                end
            end
            S_SCALE: begin
                state_d = S_OUT;
            end
            S_OUT: begin
                if (i_result_ack) begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    // Step 0 is the new sample, 1..ORDER walk the x history, ORDER+1..2*ORDER the y history.
    always_comb begin
        hist_idx = HIST_W'(step_q - STEP_W'(1));
        if (step_q >= A_BASE) begin
            hist_idx = HIST_W'(step_q - A_BASE);
        end
        operand = x_new_q;
        if (step_q >= A_BASE) begin
            operand = y_hist[ch_q][hist_idx];
        end else if (step_q != '0) begin
            operand = x_hist[ch_q][hist_idx];
        end
        prod = PROD_W'(coef_q[step_q]) * PROD_W'(operand);
    end

    always_comb begin
        shifted    = acc_q >>> COEF_FRAC;
        sat_hi     = shifted > ACC_W'(DATA_MAX);
        sat_lo     = shifted < ACC_W'(DATA_MIN);
        is_sat     = sat_hi || sat_lo;
        result_sat = shifted[DATA_W-1:0];
        if (sat_hi) begin
            result_sat = DATA_MAX;
        end else if (sat_lo) begin
            result_sat = DATA_MIN;
        end
    end

    // NOTE: every register here is updated with <= so all reads see pre-edge values.
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            // NOTE: the history arrays are reset explicitly; a reset must restart every channel from zero.
            for (int c = 0; c < NUM_CH; c++) begin
                for (int k = 0; k < ORDER; k++) begin
                    x_hist[c][k] <= '0;
                    y_hist[c][k] <= '0;
                end
            end
            for (int t = 0; t < NUM_TAPS; t++) begin
                coef_q[t] <= (t == 0) ? COEF_ONE : '0;
            end
            x_new_q        <= '0;
            ch_q           <= '0;
            step_q         <= '0;
            acc_q          <= '0;
            o_result       <= '0;
            o_result_ch    <= '0;
            o_result_valid <= 1'b0;
            o_ch_err       <= 1'b0;
        end else begin
            o_ch_err <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (i_coef_we && (int'(i_coef_addr) < NUM_TAPS)) begin
                        coef_q[i_coef_addr] <= i_coef_data;
                    end
                    if (i_NewSample_valid) begin
                        if (ch_legal) begin
                            x_new_q <= i_NewSample;
                            ch_q    <= i_NewSample_ch;
                            step_q  <= '0;
                            acc_q   <= ROUND_BIAS;
                        end else begin
                            o_ch_err <= 1'b1;
                        end
                    end
                end
                S_MAC: begin
                    acc_q <= acc_q + ACC_W'(prod);
                    if (step_q != LAST_STEP) begin
                        step_q <= step_q + STEP_W'(1);
                    end
                end
                S_SCALE: begin
                    for (int k = ORDER - 1; k > 0; k--) begin
                        x_hist[ch_q][k] <= x_hist[ch_q][k-1];
                        y_hist[ch_q][k] <= y_hist[ch_q][k-1];
                    end
                    x_hist[ch_q][0] <= x_new_q;
                    y_hist[ch_q][0] <= result_sat;
                    o_result        <= result_sat;
                    o_result_ch     <= ch_q;
                    o_result_valid  <= 1'b1;
                end
                S_OUT: begin
                    if (i_result_ack) begin
                        o_result_valid <= 1'b0;
                    end
                end
            endcase
        end
    end

`ifdef IIR_SAT_COUNT_EN
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            o_sat_cnt <= '0;
        end else if ((state_q == S_SCALE) && is_sat && (o_sat_cnt != 16'hFFFF)) begin
            o_sat_cnt <= o_sat_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_iir_filter_mc.sv
// Scoreboard bench for iir_filter_mc: stimulus pushes expected results, a monitor pops and acks.
`timescale 1ns/1ps
module tb_iir_filter_mc;

    localparam int DATA_W = 24;
    localparam int COEF_W = 18;
    localparam int LAT    = 10;

    logic i_CLK = 1'b0;
    logic i_RST;
    always #5 i_CLK = ~i_CLK;

    int cyc = 0;
    always @(posedge i_CLK) cyc <= cyc + 1;

    logic signed [DATA_W-1:0] sample;
    logic                     sample_valid;
    logic [0:0]               sample_ch;
    logic                     sample_ready;
    logic                     coef_we;
    logic [3:0]               coef_addr;
    logic signed [COEF_W-1:0] coef_data;
    logic                     busy;
    logic signed [DATA_W-1:0] res_out;
    logic [0:0]               res_ch;
    logic                     res_valid;
    logic                     i_result_ack;
    logic                     ch_err;
`ifdef IIR_SAT_COUNT_EN
    logic [15:0]              sat_cnt;
    logic [15:0]              sat_cnt3;
`endif

    iir_filter_mc dut (
        .i_CLK             (i_CLK),
        .i_RST             (i_RST),
        .i_NewSample       (sample),
        .i_NewSample_valid (sample_valid),
        .i_NewSample_ch    (sample_ch),
        .o_sample_ready    (sample_ready),
        .i_coef_we         (coef_we),
        .i_coef_addr       (coef_addr),
        .i_coef_data       (coef_data),
        .o_busy            (busy),
        .o_result          (res_out),
        .o_result_ch       (res_ch),
        .o_result_valid    (res_valid),
        .i_result_ack      (i_result_ack),
        .o_ch_err          (ch_err)
`ifdef IIR_SAT_COUNT_EN
        ,
        .o_sat_cnt         (sat_cnt)
`endif
    );

    // Second instance with a non-power-of-two channel count so index 3 is representable.
    logic signed [DATA_W-1:0] s3_data;
    logic                     s3_valid;
    logic [1:0]               s3_ch;
    logic                     r3_ready;
    logic                     r3_busy;
    logic signed [DATA_W-1:0] r3_res;
    logic [1:0]               r3_ch;
    logic                     r3_valid;
    logic                     r3_err;

    iir_filter_mc #(.NUM_CH(3)) dut3 (
        .i_CLK             (i_CLK),
        .i_RST             (i_RST),
        .i_NewSample       (s3_data),
        .i_NewSample_valid (s3_valid),
        .i_NewSample_ch    (s3_ch),
        .o_sample_ready    (r3_ready),
        .i_coef_we         (1'b0),
        .i_coef_addr       (4'd0),
        .i_coef_data       ({COEF_W{1'b0}}),
        .o_busy            (r3_busy),
        .o_result          (r3_res),
        .o_result_ch       (r3_ch),
        .o_result_valid    (r3_valid),
        .i_result_ack      (1'b1),
        .o_ch_err          (r3_err)
`ifdef IIR_SAT_COUNT_EN
        ,
        .o_sat_cnt         (sat_cnt3)
`endif
    );

    typedef struct {
        int res;
        int ch;
        int hs;
    } exp_t;

    exp_t q[$];
    int   checks    = 0;
    int   failures  = 0;
    int   ack_delay = 0;
    int   last_hs   = 0;

    task automatic check(input string name, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Monitor: compares each presented result against the scoreboard, then acks.
    initial begin : monitor
        exp_t cur;
        bit   seen;
        int   hold;
        seen = 1'b0;
        hold = 0;
        cur  = '{0, 0, 0};
        i_result_ack = 1'b0;
        forever begin
            @(negedge i_CLK);
            i_result_ack = 1'b0;
            if (i_RST) begin
                seen = 1'b0;
            end else if (res_valid) begin
                if (!seen) begin
                    seen = 1'b1;
                    hold = 0;
                    if (q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_result: got %0d on ch %0d with nothing expected", res_out, res_ch);
                        cur = '{0, 0, 0};
                    end else begin
                        cur = q.pop_front();
                        check("result", res_out, cur.res);
                        check("result_ch", res_ch, cur.ch);
                        check("latency", cyc - cur.hs, LAT);
                    end
                end else begin
                    hold++;
                    check("hold_result", res_out, cur.res);
                    check("hold_ch", res_ch, cur.ch);
                end
                if (hold >= ack_delay) i_result_ack = 1'b1;
            end else begin
                seen = 1'b0;
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while ((q.size() != 0 || busy) && n < 300) begin
            @(negedge i_CLK);
            n++;
        end
        check("drain", q.size(), 0);
    endtask

    task automatic do_reset();
        i_RST = 1'b1;
        repeat (2) @(negedge i_CLK);
        i_RST = 1'b0;
    endtask

    task automatic write_coef(input int addr, input int val);
        coef_we   = 1'b1;
        coef_addr = 4'(addr);
        coef_data = COEF_W'(val);
        @(negedge i_CLK);
        coef_we   = 1'b0;
    endtask

    task automatic send(input int val, input int ch, input bit expect_it, input int exp_val);
        int n;
        n = 0;
        while (!sample_ready && n < 200) begin
            @(negedge i_CLK);
            n++;
        end
        if (!sample_ready) check("ready_timeout", sample_ready, 1);
        sample       = DATA_W'(val);
        sample_ch    = 1'(ch);
        sample_valid = 1'b1;
        @(posedge i_CLK);
        #1;
        last_hs = cyc;
        if (expect_it) q.push_back('{exp_val, ch, cyc});
        @(negedge i_CLK);
        sample_valid = 1'b0;
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int  prev;
        int  n;
        int  hs3;
        bit  saw;
        i_RST        = 1'b1;
        sample       = '0;
        sample_valid = 1'b0;
        sample_ch    = '0;
        coef_we      = 1'b0;
        coef_addr    = '0;
        coef_data    = '0;
        s3_data      = '0;
        s3_valid     = 1'b0;
        s3_ch        = '0;
        repeat (3) @(negedge i_CLK);
        i_RST = 1'b0;

        // Reset state.
        check("rst_ready", sample_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_valid", res_valid, 0);
        check("rst_result", res_out, 0);
        check("rst_result_ch", res_ch, 0);
        check("rst_ch_err", ch_err, 0);
`ifdef IIR_SAT_COUNT_EN
        check("rst_sat_cnt", sat_cnt, 0);
`endif

        // 1. Pass-through, result held for several cycles before ack.
        ack_delay = 3;
        send(1000, 0, 1, 1000);
        check("busy_in_mac", busy, 1);
        check("ready_in_mac", sample_ready, 0);
        wait_idle();
        ack_delay = 0;

        // 2. Rounding with b0 = 0.5.
        write_coef(0, 32768);
        send(1001, 0, 1, 501);
        send(-3, 0, 1, -1);
        wait_idle();

        // 3. First-order feedback, back-to-back acceptance.
        do_reset();
        write_coef(0, 65536);
        write_coef(5, 32768);
        send(4096, 0, 1, 4096);
        prev = last_hs;
        send(0, 0, 1, 2048);
        check("b2b_gap", last_hs - prev, 12);
        prev = last_hs;
        send(0, 0, 1, 1024);
        check("b2b_gap", last_hs - prev, 12);
        send(0, 0, 1, 512);
        wait_idle();

        // 4. Channel isolation.
        do_reset();
        write_coef(0, 65536);
        write_coef(5, 32768);
        send(4096, 0, 1, 4096);
        send(100, 1, 1, 100);
        send(0, 0, 1, 2048);
        send(0, 1, 1, 50);
        wait_idle();

        // 5. Saturation both directions.
        do_reset();
        write_coef(0, 65536);
        write_coef(5, 65536);
        send(8388607, 0, 1, 8388607);
        send(8388607, 0, 1, 8388607);
        wait_idle();
`ifdef IIR_SAT_COUNT_EN
        check("sat_cnt_pos", sat_cnt, 1);
`endif
        send(-8388608, 1, 1, -8388608);
        send(-8388608, 1, 1, -8388608);
        wait_idle();
`ifdef IIR_SAT_COUNT_EN
        check("sat_cnt_neg", sat_cnt, 2);
`endif

        // 6a. Coefficient write while busy is dropped.
        do_reset();
        send(1000, 0, 1, 1000);
        coef_we   = 1'b1;
        coef_addr = 4'd0;
        coef_data = COEF_W'(32768);
        @(negedge i_CLK);
        coef_we   = 1'b0;
        wait_idle();
        send(1000, 0, 1, 1000);
        wait_idle();

        // 6b. Reset mid-MAC aborts with no result.
        send(500, 0, 0, 0);
        repeat (2) @(negedge i_CLK);
        i_RST = 1'b1;
        @(negedge i_CLK);
        i_RST = 1'b0;
        check("abort_valid", res_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_ready", sample_ready, 1);
        repeat (15) @(negedge i_CLK);
        check("abort_no_result", res_valid, 0);
        send(7, 0, 1, 7);
        wait_idle();

        // 6c. Illegal channel on the three-channel instance.
        s3_data  = DATA_W'(55);
        s3_ch    = 2'd3;
        s3_valid = 1'b1;
        @(posedge i_CLK);
        @(negedge i_CLK);
        s3_valid = 1'b0;
        check("ch_err_pulse", r3_err, 1);
        check("ch_err_busy", r3_busy, 0);
        check("ch_err_ready", r3_ready, 1);
        @(negedge i_CLK);
        check("ch_err_one_cycle", r3_err, 0);
        saw = 1'b0;
        repeat (12) begin
            @(negedge i_CLK);
            if (r3_valid) saw = 1'b1;
        end
        check("ch_err_no_result", saw, 0);
        s3_data  = -DATA_W'(9);
        s3_ch    = 2'd2;
        s3_valid = 1'b1;
        @(posedge i_CLK);
        #1;
        hs3 = cyc;
        @(negedge i_CLK);
        s3_valid = 1'b0;
        n = 0;
        while (!r3_valid && n < 40) begin
            @(negedge i_CLK);
            n++;
        end
        check("ch3_valid", r3_valid, 1);
        check("ch3_result", r3_res, -9);
        check("ch3_result_ch", r3_ch, 2);
        check("ch3_latency", cyc - hs3, LAT);
        check("ch3_no_err", r3_err, 0);

        repeat (3) @(negedge i_CLK);
        check("queue_empty", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
